// File: rtl/stopwatch_ctrl.sv
// Stopwatch digit controller: a BCD MM:SS counter with pause, per-field adjust
// and a blink mask for the field being adjusted.
module stopwatch_ctrl #(
    parameter int MIN_LIMIT = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       count_en,
    input  logic       adj_en,
    input  logic       blink_en,
    input  logic       pause_btn,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] blank,
    output logic       running
);

    typedef enum logic [1:0] {RUN, PAUSED, ADJ_MIN, ADJ_SEC} state_t;

    localparam logic [3:0] MIN_T = 4'(MIN_LIMIT / 10);
    localparam logic [3:0] MIN_O = 4'(MIN_LIMIT % 10);

    state_t     state, state_nxt;
    logic       pause, pause_nxt;
    logic       phase, phase_nxt;
    logic [3:0] min_tens_nxt, min_ones_nxt, sec_tens_nxt, sec_ones_nxt;
    logic [3:0] blank_nxt;
    logic [7:0] sec_inc, min_inc;
    logic       sec_wrap;

    // Two-digit BCD increment that returns to 00 once the limit is reached.
    function automatic logic [7:0] bcd_inc(input logic [3:0] t, input logic [3:0] o,
                                           input logic [3:0] lim_t, input logic [3:0] lim_o);
        logic [7:0] r;
        if (t == lim_t && o == lim_o) r = 8'h00;
        else if (o == 4'd9)           r = {t + 4'd1, 4'd0};
        else                          r = {t, o + 4'd1};
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            pause    <= 1'b0;
            phase    <= 1'b0;
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
            blank    <= 4'b0000;
        end else begin
            state    <= state_nxt;
            pause    <= pause_nxt;
            phase    <= phase_nxt;
            min_tens <= min_tens_nxt;
            min_ones <= min_ones_nxt;
            sec_tens <= sec_tens_nxt;
            sec_ones <= sec_ones_nxt;
            blank    <= blank_nxt;
        end
    end

    // The adjust levels take priority; otherwise the freshly toggled pause flag decides.
    always_comb begin
        pause_nxt = pause ^ pause_btn;
        if (adj)            state_nxt = sel ? ADJ_SEC : ADJ_MIN;
        else if (pause_nxt) state_nxt = PAUSED;
        else                state_nxt = RUN;
    end

    always_comb begin
        sec_inc  = bcd_inc(sec_tens, sec_ones, 4'd5, 4'd9);
        min_inc  = bcd_inc(min_tens, min_ones, MIN_T, MIN_O);
        sec_wrap = (sec_tens == 4'd5) && (sec_ones == 4'd9);
        {min_tens_nxt, min_ones_nxt} = {min_tens, min_ones};
        {sec_tens_nxt, sec_ones_nxt} = {sec_tens, sec_ones};
        // Actions follow the pre-edge state, so a strobe arriving with a mode change uses the old mode.
        case (state)
            RUN: if (count_en) begin
                {sec_tens_nxt, sec_ones_nxt} = sec_inc;
                if (sec_wrap) {min_tens_nxt, min_ones_nxt} = min_inc;
            end
            ADJ_MIN: if (adj_en) {min_tens_nxt, min_ones_nxt} = min_inc;
            ADJ_SEC: if (adj_en) {sec_tens_nxt, sec_ones_nxt} = sec_inc;
            default: ;
        endcase
        // Phase restarts at 0 whenever an adjust state is entered, including ADJ_MIN <-> ADJ_SEC.
        if ((state_nxt == ADJ_MIN || state_nxt == ADJ_SEC) && state_nxt == state)
            phase_nxt = phase ^ blink_en;
        else
            phase_nxt = 1'b0;
        if (phase_nxt && state_nxt == ADJ_MIN)      blank_nxt = 4'b1100;
        else if (phase_nxt && state_nxt == ADJ_SEC) blank_nxt = 4'b0011;
        else                                        blank_nxt = 4'b0000;
    end

    assign running = (state == RUN);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a hand-computed vector table, directed corner
// sequences and a randomized run against an integer-arithmetic model.
module tb_stopwatch_ctrl;

    localparam int MIN_LIMIT = 59;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       count_en = 0, adj_en = 0, blink_en = 0, pause_btn = 0, adj = 0, sel = 0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones, blank;
    logic       running;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: time as plain integers, mode 0=run 1=paused 2=adj min 3=adj sec.
    int m_min, m_sec, m_mode;
    bit m_pause, m_phase;

    stopwatch_ctrl #(.MIN_LIMIT(MIN_LIMIT)) dut (
        .clk(clk), .rst_n(rst_n), .count_en(count_en), .adj_en(adj_en),
        .blink_en(blink_en), .pause_btn(pause_btn), .adj(adj), .sel(sel),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
        .sec_ones(sec_ones), .blank(blank), .running(running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int digits_of(input int mm, input int ss);
        logic [15:0] d;
        d = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
        return int'(d);
    endfunction

    function automatic int dut_digits();
        return int'({min_tens, min_ones, sec_tens, sec_ones});
    endfunction

    task automatic model_reset();
        m_min = 0; m_sec = 0; m_mode = 0; m_pause = 0; m_phase = 0;
    endtask

    task automatic model_edge(input bit ce, input bit ae, input bit be, input bit pb,
                              input bit a, input bit s);
        int old_mode, new_mode;
        old_mode = m_mode;
        m_pause  = m_pause ^ pb;
        new_mode = a ? (s ? 3 : 2) : (m_pause ? 1 : 0);
        if (old_mode == 0 && ce) begin
            m_sec = m_sec + 1;
            if (m_sec == 60) begin
                m_sec = 0;
                m_min = (m_min + 1) % (MIN_LIMIT + 1);
            end
        end else if (old_mode == 2 && ae) begin
            m_min = (m_min + 1) % (MIN_LIMIT + 1);
        end else if (old_mode == 3 && ae) begin
            m_sec = (m_sec + 1) % 60;
        end
        m_phase = (new_mode >= 2 && new_mode == old_mode) ? (m_phase ^ be) : 1'b0;
        m_mode  = new_mode;
    endtask

    task automatic check_model(input string tag);
        int exp_blank;
        exp_blank = (m_phase && m_mode == 2) ? 12 : (m_phase && m_mode == 3) ? 3 : 0;
        chk({tag, "_digits"}, dut_digits(), digits_of(m_min, m_sec));
        chk({tag, "_blank"}, int'(blank), exp_blank);
        chk({tag, "_running"}, int'(running), int'(m_mode == 0));
    endtask

    // One clock: drive at negedge, predict, sample 1 ns after the posedge, drop strobes.
    task automatic step(input bit ce, input bit ae, input bit be, input bit pb,
                        input bit a, input bit s);
        @(negedge clk);
        count_en = ce; adj_en = ae; blink_en = be; pause_btn = pb; adj = a; sel = s;
        model_edge(ce, ae, be, pb, a, s);
        @(posedge clk);
        #1;
        count_en = 0; adj_en = 0; blink_en = 0; pause_btn = 0;
        check_model("model");
    endtask

    task automatic do_reset();
        @(negedge clk);
        adj = 0; sel = 0;
        rst_n = 0;
        #1;
        chk("reset_digits", dut_digits(), 0);
        chk("reset_blank", int'(blank), 0);
        chk("reset_running", int'(running), 1);
        @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    task automatic expect_time(input string name, input int mm, input int ss);
        chk(name, dut_digits(), digits_of(mm, ss));
    endtask

    typedef struct {
        bit         ce, ae, be, pb, a, s;
        int         mm, ss;
        logic [3:0] blk;
        bit         run;
    } vec_t;

    vec_t tbl[17];

    initial begin
        bit a_r, s_r;
        model_reset();
        rst_n = 1;
        #1 rst_n = 0;
        #2;
        chk("por_digits", dut_digits(), 0);
        chk("por_blank", int'(blank), 0);
        chk("por_running", int'(running), 1);
        @(negedge clk);
        rst_n = 1;

        //          ce ae be pb a  s   mm ss  blank    run
        tbl[0]  = '{1, 0, 0, 0, 0, 0,  0, 1, 4'b0000, 1};
        tbl[1]  = '{1, 1, 0, 0, 0, 0,  0, 2, 4'b0000, 1};
        tbl[2]  = '{0, 0, 0, 1, 0, 0,  0, 2, 4'b0000, 0};
        tbl[3]  = '{1, 0, 0, 0, 0, 0,  0, 2, 4'b0000, 0};
        tbl[4]  = '{0, 1, 0, 0, 0, 0,  0, 2, 4'b0000, 0};
        tbl[5]  = '{1, 0, 0, 1, 0, 0,  0, 2, 4'b0000, 1};
        tbl[6]  = '{1, 0, 0, 0, 0, 0,  0, 3, 4'b0000, 1};
        tbl[7]  = '{1, 0, 0, 0, 1, 0,  0, 4, 4'b0000, 0};
        tbl[8]  = '{0, 1, 0, 0, 1, 0,  1, 4, 4'b0000, 0};
        tbl[9]  = '{0, 0, 1, 0, 1, 0,  1, 4, 4'b1100, 0};
        tbl[10] = '{1, 0, 0, 0, 1, 0,  1, 4, 4'b1100, 0};
        tbl[11] = '{0, 0, 0, 0, 1, 1,  1, 4, 4'b0000, 0};
        tbl[12] = '{0, 1, 0, 0, 1, 1,  1, 5, 4'b0000, 0};
        tbl[13] = '{0, 0, 1, 0, 1, 1,  1, 5, 4'b0011, 0};
        tbl[14] = '{0, 0, 1, 0, 1, 1,  1, 5, 4'b0000, 0};
        tbl[15] = '{1, 0, 0, 0, 0, 0,  1, 5, 4'b0000, 1};
        tbl[16] = '{1, 0, 0, 0, 0, 0,  1, 6, 4'b0000, 1};
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].ce, tbl[i].ae, tbl[i].be, tbl[i].pb, tbl[i].a, tbl[i].s);
            chk($sformatf("vec%0d_digits", i), dut_digits(), digits_of(tbl[i].mm, tbl[i].ss));
            chk($sformatf("vec%0d_blank", i), int'(blank), int'(tbl[i].blk));
            chk($sformatf("vec%0d_running", i), int'(running), int'(tbl[i].run));
        end

        // 61 seconds from reset lands on 01:01 and keeps running.
        do_reset();
        for (int i = 0; i < 61; i++) step(1, 0, 0, 0, 0, 0);
        expect_time("count61", 1, 1);
        chk("count61_running", int'(running), 1);

        // Preload 59:59 then one second wraps the whole display.
        do_reset();
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 59; i++) step(0, 1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 59; i++) step(0, 1, 0, 0, 1, 1);
        expect_time("preload_5959", 59, 59);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        expect_time("wrap_full", 0, 0);

        // Pause holds through count strobes; resume counts again.
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0);
        expect_time("paused_hold", 0, 1);
        chk("paused_running", int'(running), 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        expect_time("resume", 0, 2);

        // Seconds adjust wraps without touching minutes; blink mask follows the field.
        do_reset();
        step(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 58; i++) step(0, 1, 0, 0, 1, 1);
        expect_time("adj_0058", 0, 58);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, 1);
        expect_time("adj_sec_wrap", 0, 1);
        step(0, 0, 1, 0, 1, 1);
        chk("blink_sec", int'(blank), 4'b0011);
        step(0, 0, 0, 0, 1, 0);
        chk("blink_clear_on_sel", int'(blank), 0);

        // Async reset pulse mid-adjust at 12:34.
        do_reset();
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 34; i++) step(0, 1, 0, 0, 1, 1);
        expect_time("adj_1234", 12, 34);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        expect_time("async_rst_digits", 0, 0);
        chk("async_rst_running", int'(running), 1);
        rst_n = 1; adj = 0; sel = 0;
        model_reset();
        step(1, 0, 0, 0, 0, 0);
        expect_time("first_after_rst", 0, 1);

        // Randomized traffic against the model.
        a_r = 0; s_r = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) a_r = ~a_r;
            if ($urandom_range(0, 19) == 0) s_r = ~s_r;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0, a_r, s_r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter MIN_LIMIT, default 59, the highest minutes value before wrap to 00 (legal 1..99).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on posedge clk.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port count_en, input, 1, one-cycle strobe at 1 Hz; advances the running count.
REQ-005 SHALL have port adj_en, input, 1, one-cycle strobe at 2 Hz; advances the adjusted field.
REQ-006 SHALL have port blink_en, input, 1, one-cycle strobe; toggles blink phase.
REQ-007 SHALL have port pause_btn, input, 1, one-cycle pulse, already debounced and edge-detected.
REQ-008 SHALL have port adj, input, 1, level; 1 = adjust mode.
REQ-009 SHALL have port sel, input, 1, level; 0 = adjust minutes, 1 = adjust seconds.
REQ-010 SHALL have ports min_tens, min_ones, sec_tens, sec_ones, output, 4 each, BCD digits, registered.
REQ-011 SHALL have port blank, output, 4, per-digit blank mask, [3]=min_tens .. [0]=sec_ones, registered.
REQ-012 SHALL have port running, output, 1, high only in state RUN.

Function
REQ-013 SHALL implement states RUN, PAUSED, ADJ_MIN, ADJ_SEC, plus an internal pause flag.
REQ-014 pause_btn SHALL toggle the pause flag in every state.
REQ-015 With adj=0, the next state SHALL be PAUSED if the pause flag is set after this cycle's toggle, else RUN.
REQ-016 With adj=1, the next state SHALL be ADJ_MIN if sel=0, else ADJ_SEC; a sel change while adj=1 SHALL switch states on the next edge.
REQ-017 In RUN on count_en, seconds SHALL increment in BCD.
- 59 -> 00 with a carry into minutes.
- Minutes MIN_LIMIT -> 00, so MIN_LIMIT:59 -> 00:00.
REQ-018 In PAUSED, all digits SHALL hold and count_en and adj_en SHALL be ignored.
REQ-019 In ADJ_MIN on adj_en, minutes SHALL increment, wrapping MIN_LIMIT -> 00; seconds hold.
REQ-020 In ADJ_SEC on adj_en, seconds SHALL increment, wrapping 59 -> 00 with no carry into minutes; minutes hold.
REQ-021 count_en SHALL be ignored in both ADJ states.
REQ-022 Actions SHALL use the current (pre-edge) state; on a same-cycle state change and strobe, the old state's action applies.
REQ-023 Digit and blank updates SHALL take effect on the edge that samples the strobe (latency 1 cycle).
REQ-024 Blink phase SHALL toggle on blink_en in ADJ states only; it SHALL be forced to 0 in RUN/PAUSED and on entry to any ADJ state.
REQ-025 blank SHALL be 4'b1100 in ADJ_MIN with phase 1, 4'b0011 in ADJ_SEC with phase 1, otherwise 4'b0000.
REQ-026 Digits SHALL never hold non-BCD values; ones digits roll 9 -> 0 with a carry into tens.
REQ-027 Simultaneous count_en and adj_en in RUN SHALL apply count_en only.

Reset
REQ-028 On rst_n=0, asynchronously:
- all digits = 0, blank = 0000
- pause flag = 0, blink phase = 0
- state = RUN, running = 1
REQ-029 Reset asserted mid-count or mid-adjust SHALL abort immediately with no partial carry retained.
REQ-030 After rst_n deasserts, the first count_en SHALL yield 00:01.

Verification
REQ-031 Reset, then 61 count_en pulses -> 01:01, running=1.
REQ-032 Preload 59:59 via adjust, adj=0, one count_en -> 00:00.
REQ-033 pause_btn, then 5 count_en -> digits unchanged, running=0; pause_btn again, then 1 count_en -> +1 second.
REQ-034 adj=1, sel=1 at 00:58, 3 adj_en -> 00:01 (no minute carry); blink_en -> blank=0011; sel=0 -> blank=0000 next cycle.
REQ-035 count_en and adj_en in the same cycle in RUN -> seconds +1 only.
REQ-036 rst_n low for 1 ns mid-adjust at 12:34 -> 00:00 immediately, state RUN.
